// File: rtl/json_pkg.sv
// Shared types for the streaming JSON validator: status codes, lexer states,
// structural byte constants and small character-class helpers.
package json_pkg;

  typedef enum logic [3:0] {
    PARSE_OK,
    PARSE_NO_VALUE,
    PARSE_INVALID_VALUE,
    PARSE_ROOT_NOT_SINGULAR,
    PARSE_MISS_QUOTATION_MARK,
    PARSE_MISS_KEY,
    PARSE_MISS_COLON,
    PARSE_MISS_COMMA_OR_CURLY_BRACKET,
    PARSE_MISS_COMMA_OR_SQUARE_BRACKET,
    PARSE_DEPTH_EXCEEDED,
    RSV
  } JSONStatus;

  typedef enum logic [4:0] {
    StValue, StLit, StNumSign, StNumZero, StNumInt, StNumFrac0, StNumFrac,
    StNumExp0, StNumExps, StNumExp, StStr, StStrEsc, StStrHex, StObjKey,
    StColon, StAfterVal, StDrain
  } json_lex_state_e;

  typedef enum logic [1:0] {LitTrue, LitFalse, LitNull} lit_sel_e;

  localparam logic [7:0] ChLBrace = 8'h7B;
  localparam logic [7:0] ChRBrace = 8'h7D;
  localparam logic [7:0] ChLBrack = 8'h5B;
  localparam logic [7:0] ChRBrack = 8'h5D;
  localparam logic [7:0] ChComma  = 8'h2C;
  localparam logic [7:0] ChColon  = 8'h3A;
  localparam logic [7:0] ChQuote  = 8'h22;
  localparam logic [7:0] ChBslash = 8'h5C;

  localparam logic [31:0] LitTrueStr  = "true";
  localparam logic [39:0] LitFalseStr = "false";
  localparam logic [31:0] LitNullStr  = "null";

  function automatic logic is_ws(logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic logic is_digit(logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic logic is_hex(logic [7:0] c);
    return is_digit(c) || ((c >= "a") && (c <= "f")) || ((c >= "A") && (c <= "F"));
  endfunction

  // Spellings are left-justified in a 40-bit word so index 0 is the top byte.
  function automatic logic [7:0] lit_char(lit_sel_e sel, logic [2:0] idx);
    logic [39:0] word;
    case (sel)
      LitTrue:  word = {LitTrueStr, 8'h00};
      LitFalse: word = LitFalseStr;
      default:  word = {LitNullStr, 8'h00};
    endcase
    return word[8'd39 - {2'b00, idx, 3'b000} -: 8];
  endfunction

  function automatic logic [2:0] lit_len(lit_sel_e sel);
    return (sel == LitFalse) ? 3'd5 : 3'd4;
  endfunction

endpackage

// File: rtl/json_stream_validator_if.sv
// Byte-stream input and registered verdict output of the JSON validator.
interface json_stream_validator_if #(
  parameter int unsigned MAX_DEPTH = 8,
  parameter int unsigned POS_W     = 16
);
  import json_pkg::*;

  localparam int unsigned DepthW = $clog2(MAX_DEPTH + 1);

  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic              res_valid;
  JSONStatus         res_status;
  logic [POS_W-1:0]  res_pos;
  logic [DepthW-1:0] depth;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, res_valid, res_status, res_pos, depth
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, res_valid, res_status, res_pos, depth
  );

endinterface

// File: rtl/json_depth_stack.sv
// One-bit-per-level nesting LIFO (0 = object, 1 = array); a push onto a full
// stack raises overflow_o and leaves the contents untouched.
module json_depth_stack #(
  parameter int unsigned MAX_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           push_val_i,
  output logic                           top_o,
  output logic                           below_o,
  output logic                           overflow_o,
  output logic [$clog2(MAX_DEPTH+1)-1:0] count_o
);
  localparam int unsigned CntW = $clog2(MAX_DEPTH + 1);
  localparam int unsigned IdxW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [MAX_DEPTH-1:0] mem_q, mem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 full;

  assign full       = (cnt_q == CntW'(MAX_DEPTH));
  assign overflow_o = push_i && full;
  assign count_o    = cnt_q;
  assign top_o      = (cnt_q != '0) ? mem_q[IdxW'(cnt_q - CntW'(1))] : 1'b0;
  assign below_o    = (cnt_q > CntW'(1)) ? mem_q[IdxW'(cnt_q - CntW'(2))] : 1'b0;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push_i && !full) begin
      mem_d[IdxW'(cnt_q)] = push_val_i;
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/json_stream_validator.sv
// Streaming JSON syntax checker: one byte per cycle, one registered verdict per
// document, never stalls. Number/literal terminators are re-lexed in AFTER_VAL.
module json_stream_validator
  import json_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = 8,
  parameter int unsigned POS_W     = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  json_stream_validator_if.slave  bus
);
  localparam int unsigned DepthW = $clog2(MAX_DEPTH + 1);

  json_lex_state_e  state_q, state_d, end_st;
  lit_sel_e         lit_sel_q, lit_sel_d;
  logic [2:0]       lit_idx_q, lit_idx_d;
  logic [1:0]       hex_cnt_q, hex_cnt_d;
  logic             is_key_q, is_key_d, empty_ok_q, empty_ok_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_inc, res_pos_q, res_pos_d;
  logic             res_valid_q, res_valid_d;
  JSONStatus        res_status_q, res_status_d, err_code, end_code;

  logic              accept, reeval, err, push, push_val, pop, clr;
  logic              stk_top, stk_below, overflow, top_next;
  logic [DepthW-1:0] cnt, cnt_next;
  logic [7:0]        c;

  assign c        = bus.s_data;
  assign accept   = bus.s_valid && rst_n;
  assign push     = accept && (state_q == StValue) && ((c == ChLBrace) || (c == ChLBrack));
  assign push_val = (c == ChLBrack);
  assign pos_inc  = (&pos_q) ? pos_q : pos_q + POS_W'(1);

  json_depth_stack #(.MAX_DEPTH(MAX_DEPTH)) u_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .push_i     (push),
    .pop_i      (pop),
    .push_val_i (push_val),
    .top_o      (stk_top),
    .below_o    (stk_below),
    .overflow_o (overflow),
    .count_o    (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StValue;
      lit_sel_q    <= LitTrue;
      lit_idx_q    <= '0;
      hex_cnt_q    <= '0;
      is_key_q     <= 1'b0;
      empty_ok_q   <= 1'b0;
      pos_q        <= '0;
      res_valid_q  <= 1'b0;
      res_status_q <= PARSE_OK;
      res_pos_q    <= '0;
    end else begin
      state_q      <= state_d;
      lit_sel_q    <= lit_sel_d;
      lit_idx_q    <= lit_idx_d;
      hex_cnt_q    <= hex_cnt_d;
      is_key_q     <= is_key_d;
      empty_ok_q   <= empty_ok_d;
      pos_q        <= pos_d;
      res_valid_q  <= res_valid_d;
      res_status_q <= res_status_d;
      res_pos_q    <= res_pos_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lit_sel_d  = lit_sel_q;
    lit_idx_d  = lit_idx_q;
    hex_cnt_d  = hex_cnt_q;
    is_key_d   = is_key_q;
    empty_ok_d = empty_ok_q;
    pop        = 1'b0;
    err        = 1'b0;
    err_code   = PARSE_OK;
    reeval     = 1'b0;
    if (accept) begin
      case (state_q)
        StValue: begin
          empty_ok_d = 1'b0;
          if (is_ws(c)) begin
            empty_ok_d = empty_ok_q;
          end else if (push) begin
            if (overflow) begin
              err      = 1'b1;
              err_code = PARSE_DEPTH_EXCEEDED;
            end else begin
              state_d    = push_val ? StValue : StObjKey;
              empty_ok_d = 1'b1;
            end
          end else if ((c == ChRBrack) && empty_ok_q) begin
            pop     = 1'b1;
            state_d = StAfterVal;
          end else if (c == ChQuote) begin
            state_d  = StStr;
            is_key_d = 1'b0;
          end else if (c == "-") state_d = StNumSign;
          else if (c == "0") state_d = StNumZero;
          else if (is_digit(c)) state_d = StNumInt;
          else if ((c == "t") || (c == "f") || (c == "n")) begin
            state_d   = StLit;
            lit_idx_d = 3'd1;
            lit_sel_d = (c == "t") ? LitTrue : ((c == "f") ? LitFalse : LitNull);
          end else begin
            err      = 1'b1;
            err_code = PARSE_INVALID_VALUE;
          end
        end
        StLit: begin
          if (c == lit_char(lit_sel_q, lit_idx_q)) begin
            lit_idx_d = lit_idx_q + 3'd1;
            if (lit_idx_q + 3'd1 == lit_len(lit_sel_q)) state_d = StAfterVal;
          end else begin
            err      = 1'b1;
            err_code = PARSE_INVALID_VALUE;
          end
        end
        StNumSign, StNumFrac0, StNumExp0, StNumExps: begin
          if ((state_q == StNumSign) && (c == "0")) state_d = StNumZero;
          else if ((state_q == StNumSign) && is_digit(c)) state_d = StNumInt;
          else if ((state_q == StNumFrac0) && is_digit(c)) state_d = StNumFrac;
          else if ((state_q == StNumExp0) && ((c == "+") || (c == "-"))) state_d = StNumExps;
          else if ((state_q != StNumSign) && (state_q != StNumFrac0) && is_digit(c)) begin
            state_d = StNumExp;
          end else begin
            err      = 1'b1;
            err_code = PARSE_INVALID_VALUE;
          end
        end
        StNumZero, StNumInt, StNumFrac, StNumExp: begin
          if (is_digit(c) && (state_q != StNumZero)) state_d = state_q;
          else if ((c == ".") && ((state_q == StNumZero) || (state_q == StNumInt))) begin
            state_d = StNumFrac0;
          end else if (((c == "e") || (c == "E")) && (state_q != StNumExp)) state_d = StNumExp0;
          else reeval = 1'b1;
        end
        StStr: begin
          if (c == ChQuote) state_d = is_key_q ? StColon : StAfterVal;
          else if (c == ChBslash) state_d = StStrEsc;
          else if (c < 8'h20) begin
            err      = 1'b1;
            err_code = PARSE_INVALID_VALUE;
          end
        end
        StStrEsc: begin
          if ((c == ChQuote) || (c == ChBslash) || (c == "/") || (c == "b") || (c == "f") ||
              (c == "n") || (c == "r") || (c == "t")) begin
            state_d = StStr;
          end else if (c == "u") begin
            state_d   = StStrHex;
            hex_cnt_d = 2'd0;
          end else begin
            err      = 1'b1;
            err_code = PARSE_INVALID_VALUE;
          end
        end
        StStrHex: begin
          if (is_hex(c)) begin
            hex_cnt_d = hex_cnt_q + 2'd1;
            if (hex_cnt_q == 2'd3) state_d = StStr;
          end else begin
            err      = 1'b1;
            err_code = PARSE_INVALID_VALUE;
          end
        end
        StObjKey: begin
          if (is_ws(c)) state_d = StObjKey;
          else if (c == ChQuote) begin
            state_d  = StStr;
            is_key_d = 1'b1;
          end else if ((c == ChRBrace) && empty_ok_q) begin
            pop     = 1'b1;
            state_d = StAfterVal;
          end else begin
            err      = 1'b1;
            err_code = PARSE_MISS_KEY;
          end
        end
        StColon: begin
          if (c == ChColon) begin
            state_d    = StValue;
            empty_ok_d = 1'b0;
          end else if (!is_ws(c)) begin
            err      = 1'b1;
            err_code = PARSE_MISS_COLON;
          end
        end
        default: ;
      endcase

      if ((state_q == StAfterVal) || reeval) begin
        state_d = StAfterVal;
        if (is_ws(c)) state_d = StAfterVal;
        else if (cnt == '0) begin
          err      = 1'b1;
          err_code = PARSE_ROOT_NOT_SINGULAR;
        end else if (c == ChComma) begin
          state_d    = stk_top ? StValue : StObjKey;
          empty_ok_d = 1'b0;
        end else if (((c == ChRBrace) && !stk_top) || ((c == ChRBrack) && stk_top)) begin
          pop = 1'b1;
        end else begin
          err      = 1'b1;
          err_code = stk_top ? PARSE_MISS_COMMA_OR_SQUARE_BRACKET
                             : PARSE_MISS_COMMA_OR_CURLY_BRACKET;
        end
      end
    end

    // Stack view after this byte, for the end-of-document verdict.
    if (push && !overflow) begin
      cnt_next = cnt + DepthW'(1);
      top_next = push_val;
    end else if (pop) begin
      cnt_next = cnt - DepthW'(1);
      top_next = stk_below;
    end else begin
      cnt_next = cnt;
      top_next = stk_top;
    end

    end_st = state_d;
    case (end_st)
      StValue:                     end_code = (cnt_next == '0) ? PARSE_NO_VALUE
                                                               : PARSE_INVALID_VALUE;
      StStr, StStrEsc, StStrHex:   end_code = PARSE_MISS_QUOTATION_MARK;
      StObjKey:                    end_code = PARSE_MISS_KEY;
      StColon:                     end_code = PARSE_MISS_COLON;
      StAfterVal, StNumZero, StNumInt, StNumFrac, StNumExp: begin
        if (cnt_next == '0) end_code = PARSE_OK;
        else end_code = top_next ? PARSE_MISS_COMMA_OR_SQUARE_BRACKET
                                 : PARSE_MISS_COMMA_OR_CURLY_BRACKET;
      end
      default:                     end_code = PARSE_INVALID_VALUE;
    endcase

    res_valid_d  = 1'b0;
    res_status_d = res_status_q;
    res_pos_d    = res_pos_q;
    pos_d        = pos_q;
    clr          = 1'b0;
    if (accept) begin
      pos_d = pos_inc;
      if (state_q == StDrain) begin
        if (bus.s_last) begin
          state_d = StValue;
          pos_d   = '0;
          clr     = 1'b1;
        end
      end else if (err) begin
        res_valid_d  = 1'b1;
        res_status_d = err_code;
        res_pos_d    = pos_q;
        clr          = 1'b1;
        state_d      = bus.s_last ? StValue : StDrain;
        if (bus.s_last) pos_d = '0;
      end else if (bus.s_last) begin
        res_valid_d  = 1'b1;
        res_status_d = end_code;
        res_pos_d    = pos_inc;
        clr          = 1'b1;
        state_d      = StValue;
        pos_d        = '0;
      end
    end
  end

  always_comb begin
    bus.s_ready    = rst_n;
    bus.res_valid  = res_valid_q;
    bus.res_status = res_status_q;
    bus.res_pos    = res_pos_q;
    bus.depth      = cnt;
  end

endmodule

// File: tb/tb_json_stream_validator.sv
// Table of JSON documents streamed back to back; a negedge monitor pops the
// expected verdict from a scoreboard queue on every res_valid pulse.
module tb_json_stream_validator;
  import json_pkg::*;

  localparam int unsigned MaxDepth = 4;
  localparam int unsigned PosW     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  json_stream_validator_if #(.MAX_DEPTH(MaxDepth), .POS_W(PosW)) bus ();

  json_stream_validator #(.MAX_DEPTH(MaxDepth), .POS_W(PosW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       doc;
    JSONStatus   st;
    int unsigned pos;
    bit          gaps;
  } vec_t;

  typedef struct {
    JSONStatus        st;
    logic [PosW-1:0]  pos;
    string            tag;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    max_depth_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic send_doc(input string s, input bit gaps, input bit mark_last);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = s[i];
      bus.s_last  = mark_last && (i == s.len() - 1);
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; (k < 20) && (sb_q.size() != 0); k++) @(posedge clk);
    @(negedge clk);
    check({tag, "_pending_results"}, sb_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{"{\"a\":[1,-2.5e+3,true,null]}", PARSE_OK, 27, 1'b0});
    vecs.push_back('{"{\"a\" 1} xx", PARSE_MISS_COLON, 5, 1'b1});
    vecs.push_back('{"[1 2] zz", PARSE_MISS_COMMA_OR_SQUARE_BRACKET, 3, 1'b0});
    vecs.push_back('{"\"abc", PARSE_MISS_QUOTATION_MARK, 4, 1'b0});
    vecs.push_back('{"   ", PARSE_NO_VALUE, 3, 1'b1});
    vecs.push_back('{"[[[[[]]]]]", PARSE_DEPTH_EXCEEDED, 4, 1'b0});
    vecs.push_back('{"[[[[]]]]", PARSE_OK, 8, 1'b1});
    vecs.push_back('{"01", PARSE_ROOT_NOT_SINGULAR, 1, 1'b0});
    vecs.push_back('{"tru", PARSE_INVALID_VALUE, 3, 1'b0});
    vecs.push_back('{"\"\\u12G4\"", PARSE_INVALID_VALUE, 5, 1'b0});
    vecs.push_back('{"1", PARSE_OK, 1, 1'b0});
    vecs.push_back('{"[]", PARSE_OK, 2, 1'b0});
    vecs.push_back('{"x", PARSE_INVALID_VALUE, 0, 1'b0});
    vecs.push_back('{"{}", PARSE_OK, 2, 1'b1});
    vecs.push_back('{"{\"k\":\"v\"}", PARSE_OK, 9, 1'b0});
    vecs.push_back('{"[1,]", PARSE_INVALID_VALUE, 3, 1'b0});
    vecs.push_back('{"{,", PARSE_MISS_KEY, 1, 1'b0});
    vecs.push_back('{"{\"a\":1 ]", PARSE_MISS_COMMA_OR_CURLY_BRACKET, 7, 1'b0});
    vecs.push_back('{"[1", PARSE_MISS_COMMA_OR_SQUARE_BRACKET, 2, 1'b0});
    vecs.push_back('{"1e+", PARSE_INVALID_VALUE, 3, 1'b0});
    vecs.push_back('{"{\"a\"", PARSE_MISS_COLON, 4, 1'b0});
    vecs.push_back('{"{\"a\":", PARSE_INVALID_VALUE, 5, 1'b0});
    vecs.push_back('{"0.5E-10 ", PARSE_OK, 8, 1'b1});
    vecs.push_back('{" null", PARSE_OK, 5, 1'b0});
    vecs.push_back('{"[true}", PARSE_MISS_COMMA_OR_SQUARE_BRACKET, 5, 1'b0});
    vecs.push_back('{"\"\\q\"", PARSE_INVALID_VALUE, 2, 1'b0});
    vecs.push_back('{"[{\"a\":[1]},\"s\\n\"]", PARSE_OK, 17, 1'b1});

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (bus.depth > max_depth_seen) max_depth_seen = int'(bus.depth);
        if (bus.res_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL spurious_res: got status %0d pos %0d, expected no result",
                     bus.res_status, bus.res_pos);
          end else begin
            e = sb_q.pop_front();
            check({e.tag, "_status"}, 32'(bus.res_status), 32'(e.st));
            check({e.tag, "_pos"}, 32'(bus.res_pos), 32'(e.pos));
          end
        end
      end
    join_none

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_s_ready", bus.s_ready, 0);
    check("reset_res_valid", bus.res_valid, 0);
    check("reset_res_status", 32'(bus.res_status), 32'(PARSE_OK));
    check("reset_res_pos", bus.res_pos, 0);
    check("reset_depth", bus.depth, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("s_ready_after_reset", bus.s_ready, 1);

    max_depth_seen = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      sb_q.push_back('{vecs[i].st, PosW'(vecs[i].pos), $sformatf("vec%0d", i)});
      send_doc(vecs[i].doc, vecs[i].gaps, 1'b1);
      if (i == 0) begin
        @(negedge clk);
        check("vec0_depth_peak", max_depth_seen, 2);
      end
    end
    wait_drain("table");

    // Reset in the middle of a document must drop it silently.
    send_doc("{\"k\"", 1'b0, 1'b0);
    check("mid_doc_depth", bus.depth, 1);
    rst_n = 1'b0;
    #2;
    check("mid_reset_depth", bus.depth, 0);
    check("mid_reset_res_valid", bus.res_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_depth", bus.depth, 0);
    sb_q.push_back('{PARSE_OK, PosW'(2), "after_reset"});
    send_doc("[]", 1'b0, 1'b1);
    wait_drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/json_stream_validator.md
# json_stream_validator

Synthesizable streaming JSON syntax checker: consumes one byte per cycle and, at document end or first error, reports a `JSONStatus` verdict with the failing byte offset. It is the hardware successor to the class-based parser in `json_pkg`, producing the same status codes. It is generalised with a parametrised nesting depth, zero-bubble back-to-back documents, and depth-overflow detection. It sits between a byte-stream source (DMA/UART deframer) and downstream logic that needs a pass/fail result on each JSON document.

## Interface
- `MAX_DEPTH`, 8: maximum object/array nesting (≥1).
- `POS_W`, 16: width of byte-offset counter; saturates at all-ones.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: 0 while `rst_n`=0, 1 otherwise (the block never stalls).
- `s_data` in 8: input byte.
- `s_last` in 1: marks the final byte of a document.
- `res_valid` out 1: one-cycle result pulse, exactly once per document.
- `res_status` out `JSONStatus`: verdict, held until the next `res_valid`.
- `res_pos` out `POS_W`: 0-based offset of the offending byte (PARSE_OK: byte count), held.
- `depth` out `$clog2(MAX_DEPTH+1)`: current nesting level (live).

## Operation
- A byte is accepted when `s_valid && s_ready`. Whitespace is 0x20, 0x09, 0x0A and 0x0D.
- Grammar:
  - Values: literals `true`, `false`, `null`.
  - Numbers: `-`? (`0` | [1-9][0-9]*) (`.`[0-9]+)? ([eE][+-]?[0-9]+)?.
  - Strings: bytes ≥0x20. Escapes are `\" \\ \/ \b \f \n \r \t \uXXXX`, where XXXX is exactly 4 hex digits.
  - Objects and arrays per RFC 8259.
- Numbers and literals end on a delimiter. The delimiter byte is re-evaluated in the same cycle by the post-value state, with no extra cycle.
- States:
  - VALUE: expect a value.
  - LIT: literal match with a 3-bit index.
  - Number states: NUM_SIGN, NUM_ZERO, NUM_INT, NUM_FRAC0, NUM_FRAC, NUM_EXP0, NUM_EXPS, NUM_EXP.
  - STR, STR_ESC, STR_HEX (2-bit count), with an `is_key` flag.
  - OBJ_KEY: expect `"`, or `}` only if the object is empty.
  - COLON.
  - AFTER_VAL: `,` or a closer matching the stack top. At depth 0, whitespace only.
  - DRAIN: after an error, discard bytes until `s_last`.
- Error mapping at the offending byte:
  - Bad value start, bad literal/number/string char, or bad escape → PARSE_INVALID_VALUE.
  - Non-whitespace after the root value → PARSE_ROOT_NOT_SINGULAR.
  - Non-`"` in OBJ_KEY → PARSE_MISS_KEY.
  - Non-`:` after a key → PARSE_MISS_COLON.
  - In AFTER_VAL, object top → PARSE_MISS_COMMA_OR_CURLY_BRACKET; array top → PARSE_MISS_COMMA_OR_SQUARE_BRACKET.
  - `{`/`[` at depth MAX_DEPTH → PARSE_DEPTH_EXCEEDED.
- End-of-document on `s_last` with no prior error. The last byte is processed first, then:
  - Whitespace-only document → PARSE_NO_VALUE.
  - Inside a string → PARSE_MISS_QUOTATION_MARK.
  - OBJ_KEY → PARSE_MISS_KEY.
  - COLON → PARSE_MISS_COLON.
  - Depth>0 in AFTER_VAL → the MISS_COMMA code for the stack top.
  - VALUE at depth>0, incomplete literal, or number ending in NUM_SIGN/FRAC0/EXP0/EXPS → PARSE_INVALID_VALUE.
  - Otherwise PARSE_OK.
  - For end-of-document errors, `res_pos` = byte count.
- An error detected on the `s_last` byte gives a single `res_valid`; DRAIN is skipped. Afterwards the state returns to VALUE, depth resets to 0 and the position resets to 0.

## Timing
- `res_valid` asserts the cycle after the byte that ends the document (`s_last`) or that triggers the error. Outputs are registered.
- After an error, `s_last` of the drained document produces no second `res_valid`.
- A new document's first byte may arrive the cycle after `s_last`, coincident with `res_valid`. No bubble is permitted.
- Reset values: `res_valid`=0, `res_status`=PARSE_OK, `res_pos`=0, `depth`=0, state VALUE.
- Reset mid-document discards the document and produces no result.
- Idle cycles (`s_valid`=0) change no state.

## Structure
- `json_pkg`:
  - Append `PARSE_DEPTH_EXCEEDED` immediately before `RSV`.
  - Add typedef `json_lex_state_e` and localparam byte constants for structural characters and literal spellings.
- Sub-module `json_depth_stack`: a MAX_DEPTH-entry 1-bit LIFO (0=object, 1=array).
  - Push/pop in one cycle; `top` and `count` are combinational.
  - Overflow is flagged, never written.

## Test plan
- `{"a":[1,-2.5e+3,true,null]}` with `s_last` → PARSE_OK, `res_pos`=27, one `res_valid`; `depth` peaks at 2.
- `{"a" 1}` → PARSE_MISS_COLON at pos 5; `[1 2]` → PARSE_MISS_COMMA_OR_SQUARE_BRACKET at pos 3; both with trailing bytes drained.
- `"abc` + `s_last` → PARSE_MISS_QUOTATION_MARK, pos 4. Three spaces + `s_last` → PARSE_NO_VALUE, pos 3.
- MAX_DEPTH=4, input `[[[[[` → PARSE_DEPTH_EXCEEDED at pos 4. A depth-4 array nest still passes.
- `01` → PARSE_ROOT_NOT_SINGULAR at pos 1. `tru` + `s_last` → PARSE_INVALID_VALUE, pos 3. `"\u12G4"` → PARSE_INVALID_VALUE at pos 5.
- Back-to-back documents `1` `[]` `x`, one byte per cycle → three `res_valid` pulses: OK, OK, INVALID_VALUE at pos 0. Then `rst_n` pulses mid-`{"k"` → no `res_valid`, and `depth`=0.
